// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3004/3008 conversion controller.
// Edge numbers count AD_CLK rising edges from 1 within a 17-period frame.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam int FRAME_CLKS      = 17;
    localparam int DATA_FIRST_EDGE = 8;
    localparam int ADC_BITS        = 10;
    localparam int CNT_W           = 16;

    // Command bits in transmit order: start, SGL/DIFF, D2, D1, D0.
    function automatic logic [4:0] cmd_word(input logic sgl, input logic [2:0] ch);
        return {1'b1, sgl, ch};
    endfunction

endpackage

// File: rtl/sclk_gen.sv
// Half-period divider: one strobe every CLK_DIV clk, alternating rise/fall, phase reset by restart.
// Latency: first strobe CLK_DIV-1 clk after restart; counter frozen while en is low.
// Backpressure: none, free-running while enabled.
module sclk_gen #(
    parameter int CLK_DIV = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          phase;
    logic          tick;

    assign tick      = en && (div_cnt == DW'(CLK_DIV - 1));
    assign rise_tick = tick && !phase;
    assign fall_tick = tick && phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (restart) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcp3008_reader.sv
// MCP3004/3008 SPI conversion controller with a one-entry valid/ready output register.
// Latency: sample_valid 33*CLK_DIV+1 clk after SETUP entry; ADC_AVG_EN emits one mean per 4 conversions.
// Backpressure: a result arriving while the register is full and not consumed is dropped and flags overrun.
module mcp3008_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV         = 150,
    parameter int CS_HIGH_PERIODS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic [2:0]          channel,
    input  logic                single_ended,
    output logic [ADC_BITS-1:0] sample,
    output logic [2:0]          sample_channel,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic                AD_CLK,
    output logic                CS,
    output logic                DIN,
    input  logic                DOUT
);

    // Half-period indices within a frame; index 0 is the SETUP tick (rising edge 1).
    localparam int LAST_RISE  = 2 * (FRAME_CLKS - 1);
    localparam int DATA_START = 2 * (DATA_FIRST_EDGE - 1);
    localparam int SHIFT_END  = 2 * FRAME_CLKS;
    localparam int HOLD_END   = SHIFT_END + 2 * CS_HIGH_PERIODS;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    half_cnt;
    logic                rise_tick, fall_tick, tick;
    logic                enter_setup;
    logic [2:0]          ch_lat;
    logic                sgl_lat;
    logic [4:0]          cmd;
    logic [1:0]          cmd_idx;
    logic [ADC_BITS-1:0] shreg;
    logic                done_q;
    logic                emit;
    logic [ADC_BITS-1:0] emit_dat;
    logic                consume;

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .rst       (rst),
        .en        (state != IDLE),
        .restart   (enter_setup),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign tick = rise_tick || fall_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        CS        = 1'b1;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SETUP;
            end
            SETUP: begin
                CS   = 1'b0;
                busy = 1'b1;
                if (tick) state_nxt = SHIFT;
            end
            SHIFT: begin
                CS   = 1'b0;
                busy = 1'b1;
                if (tick && half_cnt == CNT_W'(SHIFT_END)) state_nxt = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (tick && half_cnt == CNT_W'(HOLD_END))
                    state_nxt = (start && continuous) ? SETUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_setup = (state_nxt == SETUP) && (state != SETUP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            ch_lat   <= '0;
            sgl_lat  <= 1'b0;
        end else if (enter_setup) begin
            half_cnt <= '0;
            ch_lat   <= channel;
            sgl_lat  <= single_ended;
        end else if (tick) begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    // Falls happen on odd half indices 1,3,5,7; each presents the next command bit.
    assign cmd     = cmd_word(sgl_lat, ch_lat);
    assign cmd_idx = 2'd3 - half_cnt[2:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AD_CLK <= 1'b0;
            DIN    <= 1'b0;
        end else begin
            if (rise_tick && (state == SETUP ||
                              (state == SHIFT && half_cnt < CNT_W'(SHIFT_END))))
                AD_CLK <= 1'b1;
            else if (fall_tick)
                AD_CLK <= 1'b0;

            if (enter_setup)
                DIN <= 1'b1;
            else if (fall_tick && state == SHIFT)
                DIN <= (half_cnt < CNT_W'(8)) ? cmd[cmd_idx] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            if (rise_tick && state == SHIFT &&
                half_cnt >= CNT_W'(DATA_START) && half_cnt <= CNT_W'(LAST_RISE))
                shreg <= {shreg[ADC_BITS-2:0], DOUT};
            done_q <= rise_tick && state == SHIFT && half_cnt == CNT_W'(LAST_RISE);
        end
    end

`ifdef ADC_AVG_EN
    logic [11:0] acc;
    logic [11:0] acc_sum;
    logic [1:0]  avg_cnt;
    logic [2:0]  prev_ch;

    assign acc_sum  = acc + {2'b00, shreg};
    assign emit     = done_q && (ch_lat == prev_ch) && (avg_cnt == 2'd3);
    assign emit_dat = acc_sum[11:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            avg_cnt <= '0;
            prev_ch <= '0;
        end else if (done_q) begin
            prev_ch <= ch_lat;
            if (ch_lat != prev_ch) begin
                acc     <= {2'b00, shreg};
                avg_cnt <= 2'd1;
            end else if (avg_cnt == 2'd3) begin
                acc     <= '0;
                avg_cnt <= 2'd0;
            end else begin
                acc     <= acc_sum;
                avg_cnt <= avg_cnt + 1'b1;
            end
        end
    end
`else
    assign emit     = done_q;
    assign emit_dat = shreg;
`endif

    assign consume = sample_valid && sample_ready;

    // A consume in the same cycle frees the register, so the new result is taken, not dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample         <= '0;
            sample_channel <= '0;
            sample_valid   <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (emit && (!sample_valid || consume)) begin
                sample         <= emit_dat;
                sample_channel <= ch_lat;
                sample_valid   <= 1'b1;
            end else if (consume) begin
                sample_valid <= 1'b0;
            end
            overrun <= (emit && sample_valid && !consume) || (overrun && !overrun_clr);
        end
    end

endmodule

// File: tb/tb_mcp3008_reader.sv
// Bench for mcp3008_reader: a behavioural MCP3008 drives DOUT per frame; timing and data
// expectations come from the frame arithmetic of the ADC protocol.
module tb_mcp3008_reader;

    localparam int CD        = 2;
    localparam int HP        = 2;
    localparam int VALID_LAT = 33 * CD + 1;
    localparam int PERIOD    = (35 + 2 * HP) * CD;
    localparam int CS_GAP    = 2 * HP * CD;
    localparam int LIMIT     = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, continuous = 1'b0, single_ended = 1'b0;
    logic [2:0] channel = 3'd0;
    logic [9:0] sample;
    logic [2:0] sample_channel;
    logic       sample_valid, sample_ready = 1'b0, busy, overrun, overrun_clr = 1'b0;
    logic       AD_CLK, CS, DIN;
    logic       DOUT = 1'b0;

    int tests = 0, fails = 0;

    mcp3008_reader #(.CLK_DIV(CD), .CS_HIGH_PERIODS(HP)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .channel(channel), .single_ended(single_ended), .sample(sample),
        .sample_channel(sample_channel), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .overrun(overrun),
        .overrun_clr(overrun_clr), .AD_CLK(AD_CLK), .CS(CS), .DIN(DIN), .DOUT(DOUT)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ADC model: a conversion value per CS-low frame, bits driven after falling edges.
    logic [9:0] adc_mem [64];
    int         adc_wr = 0, adc_rd = 0;
    logic [9:0] cur = '0;
    logic [4:0] din_bits = '0;
    logic       prev_cs = 1'b1, prev_ad = 1'b0;
    int         setup_cyc = 0, cs_rise_cyc = 0, cs_high_len = 0;
    int         frames_done = 0, rise_cnt = 0, fall_cnt = 0;

    always @(CS or AD_CLK) begin
        if (prev_cs === 1'b1 && CS === 1'b0) begin
            setup_cyc   = cyc;
            cs_high_len = cyc - cs_rise_cyc;
            rise_cnt    = 0;
            fall_cnt    = 0;
            if (adc_rd < adc_wr) begin
                cur = adc_mem[6'(adc_rd)];
                adc_rd++;
            end else begin
                cur = 10'($urandom);
            end
        end
        if (prev_cs === 1'b0 && CS === 1'b1) begin
            cs_rise_cyc = cyc;
            if (rst === 1'b0) frames_done++;
        end
        if (prev_ad === 1'b0 && AD_CLK === 1'b1) begin
            rise_cnt++;
            if (rise_cnt <= 5) din_bits[3'(5 - rise_cnt)] = DIN;
        end
        if (prev_ad === 1'b1 && AD_CLK === 1'b0 && CS === 1'b0) begin
            fall_cnt++;
            DOUT = (fall_cnt >= 7 && fall_cnt <= 16) ? cur[4'(16 - fall_cnt)] : 1'b0;
        end
        prev_cs = CS;
        prev_ad = AD_CLK;
    end

    int valid_cyc = 0, valid_cnt = 0;
    always @(posedge sample_valid) begin
        valid_cyc = cyc;
        valid_cnt++;
    end

    task automatic push_adc(input logic [9:0] d);
        adc_mem[6'(adc_wr)] = d;
        adc_wr++;
    endtask

    task automatic wait_valid(input int target, output bit ok);
        int n = 0;
        while (valid_cnt < target && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        ok = (valid_cnt >= target);
    endtask

    task automatic wait_frames(input int target, output bit ok);
        int n = 0;
        while (frames_done < target && n < LIMIT * 4) begin
            @(posedge clk); #1; n++;
        end
        ok = (frames_done >= target);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (CS !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b want 1", CS); end
        tests++; if (AD_CLK !== 1'b0) begin fails++; $display("FAIL reset_adclk: got %b want 0", AD_CLK); end
        tests++; if (DIN !== 1'b0) begin fails++; $display("FAIL reset_din: got %b want 0", DIN); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        tests++; if (sample !== 10'd0 || sample_channel !== 3'd0) begin
            fails++; $display("FAIL reset_sample: got %h/%0d want 0/0", sample, sample_channel);
        end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0 || CS !== 1'b1) begin
            fails++; $display("FAIL idle_after_reset: busy %b cs %b want 0 1", busy, CS);
        end
    endtask

    task automatic test_single(input logic [2:0] ch, input logic sgl, input logic [9:0] d);
        int v0;
        bit ok;
        push_adc(d);
        v0 = valid_cnt;
        @(negedge clk);
        channel = ch; single_ended = sgl; start = 1'b1;
        @(negedge clk);
        start = 1'b0; channel = ~ch; single_ended = ~sgl;
        tests++; if (busy !== 1'b1 || CS !== 1'b0) begin
            fails++; $display("FAIL single_busy: busy %b cs %b want 1 0", busy, CS);
        end
        wait_valid(v0 + 1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_timeout: valid count %0d want %0d", valid_cnt, v0 + 1); end
        tests++; if (valid_cyc - setup_cyc !== VALID_LAT) begin
            fails++; $display("FAIL single_latency: got %0d want %0d", valid_cyc - setup_cyc, VALID_LAT);
        end
        tests++; if (sample !== d) begin fails++; $display("FAIL single_sample: got %h want %h", sample, d); end
        tests++; if (sample_channel !== ch) begin
            fails++; $display("FAIL single_channel: got %0d want %0d", sample_channel, ch);
        end
        tests++; if (din_bits !== {1'b1, sgl, ch}) begin
            fails++; $display("FAIL single_din: got %b want %b", din_bits, {1'b1, sgl, ch});
        end
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL single_consume: valid %b want 0", sample_valid); end
        wait_idle(ok);
        tests++; if (!ok || CS !== 1'b1) begin fails++; $display("FAIL single_idle: busy %b cs %b want 0 1", busy, CS); end
    endtask

    task automatic test_continuous();
        logic [9:0] d [4];
        int vc [4];
        int v0;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            d[k] = 10'($urandom);
            push_adc(d[k]);
        end
        v0 = valid_cnt;
        @(negedge clk);
        sample_ready = 1'b1; continuous = 1'b1; channel = 3'($urandom); start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(v0 + k + 1, ok);
            vc[k] = valid_cyc;
            tests++; if (!ok || sample !== d[k]) begin
                fails++; $display("FAIL cont_sample%0d: got %h want %h", k, sample, d[k]);
            end
            if (k > 0) begin
                tests++; if (vc[k] - vc[k-1] !== PERIOD) begin
                    fails++; $display("FAIL cont_period%0d: got %0d want %0d", k, vc[k] - vc[k-1], PERIOD);
                end
                tests++; if (cs_high_len !== CS_GAP) begin
                    fails++; $display("FAIL cont_cs_gap%0d: got %0d want %0d", k, cs_high_len, CS_GAP);
                end
            end
            tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL cont_overrun%0d: got %b want 0", k, overrun); end
        end
        start = 1'b0; continuous = 1'b0;
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL cont_idle: busy %b want 0", busy); end
        sample_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_overrun();
        logic [9:0] d0;
        int f0;
        bit ok;
        d0 = 10'($urandom);
        push_adc(d0);
        push_adc(~d0);
        push_adc(d0 ^ 10'h155);
        f0 = frames_done;
        @(negedge clk);
        sample_ready = 1'b0; continuous = 1'b1; start = 1'b1;
        wait_frames(f0 + 1, ok);
        tests++; if (!ok || sample_valid !== 1'b1 || sample !== d0 || overrun !== 1'b0) begin
            fails++; $display("FAIL ovr_frame1: valid %b sample %h overrun %b want 1 %h 0", sample_valid, sample, overrun, d0);
        end
        wait_frames(f0 + 2, ok);
        tests++; if (!ok || overrun !== 1'b1 || sample !== d0) begin
            fails++; $display("FAIL ovr_frame2: overrun %b sample %h want 1 %h", overrun, sample, d0);
        end
        wait_frames(f0 + 3, ok);
        start = 1'b0; continuous = 1'b0;
        tests++; if (!ok || overrun !== 1'b1 || sample !== d0 || sample_valid !== 1'b1) begin
            fails++; $display("FAIL ovr_frame3: overrun %b sample %h valid %b want 1 %h 1", overrun, sample, sample_valid, d0);
        end
        wait_idle(ok);
        @(negedge clk) overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain: valid %b want 0", sample_valid); end
    endtask

    task automatic test_ready_same_cycle();
        logic [9:0] a, b;
        int v0, e;
        bit ok;
        a = 10'($urandom);
        b = ~a;
        push_adc(a);
        push_adc(b);
        v0 = valid_cnt;
        @(negedge clk);
        sample_ready = 1'b0; continuous = 1'b1; start = 1'b1;
        wait_valid(v0 + 1, ok);
        e = valid_cyc;
        tests++; if (!ok || sample !== a) begin fails++; $display("FAIL same_first: got %h want %h", sample, a); end
        while (cyc < e + PERIOD - 1) begin
            @(posedge clk); #1;
        end
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        start = 1'b0; continuous = 1'b0;
        tests++; if (sample !== b || sample_valid !== 1'b1 || overrun !== 1'b0) begin
            fails++; $display("FAIL same_cycle: sample %h valid %b overrun %b want %h 1 0", sample, sample_valid, overrun, b);
        end
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL same_idle: busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        push_adc(10'($urandom));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rise_cnt < 10 && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        tests++; if (rise_cnt !== 10) begin fails++; $display("FAIL mid_rise10: got %0d want 10", rise_cnt); end
        rst = 1'b1;
        #1;
        tests++; if (CS !== 1'b1 || AD_CLK !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            fails++; $display("FAIL mid_reset: cs %b adclk %b busy %b valid %b want 1 0 0 0", CS, AD_CLK, busy, sample_valid);
        end
        @(negedge clk) rst = 1'b0;
        test_single(3'($urandom), 1'($urandom), 10'($urandom));
    endtask

`ifdef ADC_AVG_EN
    task automatic test_avg();
        int vals [4] = '{100, 101, 102, 104};
        int sum = 0;
        int v0, f0;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            push_adc(10'(vals[k]));
            sum += vals[k];
        end
        v0 = valid_cnt;
        f0 = frames_done;
        @(negedge clk);
        sample_ready = 1'b1; continuous = 1'b1; channel = 3'd2; start = 1'b1;
        wait_frames(f0 + 4, ok);
        start = 1'b0; continuous = 1'b0;
        wait_idle(ok);
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL avg_count: got %0d want 1", valid_cnt - v0); end
        tests++; if (sample !== 10'(sum / 4)) begin fails++; $display("FAIL avg_value: got %0d want %0d", sample, sum / 4); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_AVG_EN
        test_avg();
`else
        test_single(3'd5, 1'b1, 10'h2A5);
        for (int i = 0; i < 3; i++) test_single(3'($urandom), 1'($urandom), 10'($urandom));
        test_continuous();
        test_overrun();
        test_ready_same_cycle();
        test_reset_mid_frame();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
